vga_scanout: RTL and testbench

- Downstream stage of the VGA timing controller; consumes sx/sy/hsync/vsync/de in the pixel clock domain.
- Fetches one line of pixels ahead into a ping-pong line buffer through a valid/ready stream, then drives RGB to the display output.
- Delays sync and data-enable to match the pixel pipeline latency, and reports fill underruns.

---
 rtl/vdp_pkg.sv | 23 ++
 rtl/vga_scanout_if.sv | 27 ++
 rtl/linebuf_dp.sv | 34 +++
 rtl/vga_scanout.sv | 136 +++++++++++++
 tb/tb_vga_scanout.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the video datapath: default timing constants,
// the packed pixel type, the line-fill state encoding and a line-advance helper.
package vdp_pkg;

   localparam int H_RES  = 640;  // active pixels per line
   localparam int VA_END = 479;  // last active line
   localparam int SCREEN = 524;  // last line of the frame
   localparam int LINE   = 799;  // last horizontal position of a line
   localparam int CW     = 4;    // bits per colour channel

   typedef logic [3*CW-1:0] rgb_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Line that follows y, wrapping after the last line of the frame.
   function automatic logic [9:0] next_line(input logic [9:0] y, input logic [9:0] last);
      return (y == last) ? 10'd0 : y + 10'd1;
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Line-fetch request and pixel stream between the scanout and its pixel source.
// master = pixel source, slave = scanout (consumer).
interface vga_scanout_if #(
   parameter int CW = vdp_pkg::CW
);
   logic              fetch_req;
   logic [9:0]        fetch_y;
   logic              in_valid;
   logic              in_ready;
   logic [3*CW-1:0]   in_data;

   modport master (
      input  fetch_req,
      input  fetch_y,
      input  in_ready,
      output in_valid,
      output in_data
   );

   modport slave (
      output fetch_req,
      output fetch_y,
      output in_ready,
      input  in_valid,
      input  in_data
   );
endinterface

// File: rtl/linebuf_dp.sv
// Ping-pong line buffer: two banks of H_RES pixels, one write port and one
// read port with a registered (one-cycle) read. Address is {bank, index}.
module linebuf_dp #(
   parameter int H_RES  = vdp_pkg::H_RES,
   parameter int DATA_W = 3 * vdp_pkg::CW,
   parameter int IW     = $clog2(H_RES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IW:0]       waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IW:0]       raddr,
   output logic [DATA_W-1:0] rdata
);
   import vdp_pkg::*;

   logic [DATA_W-1:0] r_mem [2][H_RES];
   logic [DATA_W-1:0] r_rdata_p1;

   // Write port: store one pixel into the bank currently being filled.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr[IW]][waddr[IW-1:0]] <= wdata;
      end
   end

   // Read port: registered read, contents are never cleared.
   always_ff @(posedge clk) begin
      r_rdata_p1 <= r_mem[raddr[IW]][raddr[IW-1:0]];
   end

   assign rdata = r_rdata_p1;

endmodule

// File: rtl/vga_scanout.sv
// Display scanout: fetches the next line into a ping-pong buffer while the
// current line is displayed, and drives RGB with sync/de delayed by the same
// two-cycle pipeline as the pixel read. Reports late fills as a sticky underrun.
module vga_scanout #(
   parameter int H_RES  = vdp_pkg::H_RES,
   parameter int VA_END = vdp_pkg::VA_END,
   parameter int SCREEN = vdp_pkg::SCREEN,
   parameter int CW     = vdp_pkg::CW
) (
   input  logic              clk_pix,
   input  logic              rst_pix_n,
   input  logic [9:0]        sx,
   input  logic [9:0]        sy,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              de_in,
   vga_scanout_if.slave      src,
   output logic              underrun,
   input  logic              underrun_clr,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [3*CW-1:0]   rgb
);
   import vdp_pkg::*;

   localparam int IW = $clog2(H_RES);

   fill_state_e       r_state;
   logic [IW-1:0]     r_count;
   logic              r_wbank;
   logic              r_fetch_req;
   logic [9:0]        r_fetch_y;
   logic              r_underrun;

   logic [9:0]        w_next_y;
   logic              w_trigger;
   logic              w_hs;
   logic              w_last;
   logic              w_missed;
   logic [3*CW-1:0]   w_ram_q;

   logic              r_hsync_p1;
   logic              r_vsync_p1;
   logic              r_de_p1;
   logic              r_hsync_p2;
   logic              r_vsync_p2;
   logic              r_de_p2;
   logic [3*CW-1:0]   r_rgb_p2;

   // A fill for line next_y starts at the first pixel slot of the line before it;
   // lines past VA_END are never fetched (line 0 is fetched during line SCREEN).
   assign w_next_y  = next_line(sy, 10'(SCREEN));
   assign w_trigger = (sx == 10'd0) && (w_next_y <= 10'(VA_END));
   assign w_hs      = (r_state == FILL) && src.in_valid;
   assign w_last    = w_hs && (r_count == IW'(H_RES - 1));
   // A fill still open at the next trigger missed its deadline, unless the
   // final pixel lands in that very cycle.
   assign w_missed  = w_trigger && (r_state == FILL) && !w_last;

   // Fill controller: request a line, accept H_RES pixels, flag missed deadlines.
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_wbank     <= 1'b0;
         r_fetch_req <= 1'b0;
         r_fetch_y   <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_fetch_req <= w_trigger;
         if (w_trigger) begin
            r_state   <= FILL;
            r_count   <= '0;
            r_fetch_y <= w_next_y;
            r_wbank   <= w_next_y[0];
         end else if (w_hs) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
               r_state <= IDLE;
            end
         end
         if (w_missed) begin
            r_underrun <= 1'b1;
         end else if (underrun_clr) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign src.fetch_req = r_fetch_req;
   assign src.fetch_y   = r_fetch_y;
   assign src.in_ready  = (r_state == FILL);
   assign underrun      = r_underrun;

   // Display reads bank sy[0]; during active lines the fill always targets the other bank.
   linebuf_dp #(
      .H_RES  (H_RES),
      .DATA_W (3 * CW),
      .IW     (IW)
   ) u_linebuf (
      .clk   (clk_pix),
      .we    (w_hs),
      .waddr ({r_wbank, r_count}),
      .wdata (src.in_data),
      .raddr ({sy[0], sx[IW-1:0]}),
      .rdata (w_ram_q)
   );

   // Stage 1 -> 2: RAM read in flight, sync/de follow alongside; blank outside de.
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         r_hsync_p1 <= 1'b1;
         r_vsync_p1 <= 1'b1;
         r_de_p1    <= 1'b0;
         r_hsync_p2 <= 1'b1;
         r_vsync_p2 <= 1'b1;
         r_de_p2    <= 1'b0;
         r_rgb_p2   <= '0;
      end else begin
         r_hsync_p1 <= hsync_in;
         r_vsync_p1 <= vsync_in;
         r_de_p1    <= de_in;
         r_hsync_p2 <= r_hsync_p1;
         r_vsync_p2 <= r_vsync_p1;
         r_de_p2    <= r_de_p1;
         r_rgb_p2   <= r_de_p1 ? w_ram_q : '0;
      end
   end

   assign hsync = r_hsync_p2;
   assign vsync = r_vsync_p2;
   assign de    = r_de_p2;
   assign rgb   = r_rgb_p2;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster (32 active pixels, 48-cycle lines,
// 16-line frame). The bench plays both the timing controller and the pixel
// source, and predicts every output from the raster/fill rules directly.
module tb_vga_scanout;

   localparam int H     = 32;
   localparam int VA    = 11;
   localparam int SCR   = 15;
   localparam int LN    = 48;
   localparam int FRAME = LN * (SCR + 1);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  sx, sy;
   logic        hs_in, vs_in, de_in;
   logic        underrun, underrun_clr;
   logic        hsync, vsync, de;
   logic [11:0] rgb;

   vga_scanout_if #(.CW(4)) bus ();

   vga_scanout #(
      .H_RES  (H),
      .VA_END (VA),
      .SCREEN (SCR),
      .CW     (4)
   ) dut (
      .clk_pix      (clk),
      .rst_pix_n    (rst_n),
      .sx           (sx),
      .sy           (sy),
      .hsync_in     (hs_in),
      .vsync_in     (vs_in),
      .de_in        (de_in),
      .src          (bus.slave),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .hsync        (hsync),
      .vsync        (vsync),
      .de           (de),
      .rgb          (rgb)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sx;
      int sy;
      bit hs;
      bit vs;
      bit de;
      bit rst_n;
      bit valid;
      bit clr;
      bit active;
   } drv_t;

   int   checks = 0;
   int   errors = 0;
   drv_t h1, h2;
   int   tx, ty;
   bit   rnd_mode, drop_mode, stall_mode, chk_img;
   bit   drv_rst_n, drv_clr;
   bit   src_active;
   int   src_idx, src_line, drops;
   bit   exp_under;
   int   exp_fy;

   function automatic int ny(input int y);
      return (y == SCR) ? 0 : y + 1;
   endfunction

   function automatic bit trig(input int x, input int y);
      return (x == 0) && (ny(y) <= VA);
   endfunction

   function automatic logic [11:0] pix(input int x, input int y);
      logic [9:0] xb, yb;
      xb = x[9:0];
      yb = y[9:0];
      return {yb[3:0], xb[7:4], xb[3:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: update the reference from what was applied last cycle, compare,
   // then apply the next cycle's inputs.
   task automatic step();
      bit          fr_exp, setu, v;
      bit          ehs, evs, ede;
      logic [11:0] data;
      drv_t        d;
      @(posedge clk);
      #1;
      fr_exp = 1'b0;
      if (h1.rst_n && h1.valid && h1.active) begin
         src_idx++;
         if (src_idx == H) src_active = 1'b0;
      end
      if (!h1.rst_n) begin
         src_active = 1'b0;
         exp_under  = 1'b0;
         exp_fy     = 0;
      end else begin
         setu = trig(h1.sx, h1.sy) && src_active;
         if (setu) exp_under = 1'b1;
         else if (h1.clr) exp_under = 1'b0;
         if (trig(h1.sx, h1.sy)) begin
            src_active = 1'b1;
            src_idx    = 0;
            src_line   = ny(h1.sy);
            exp_fy     = src_line;
            drops      = 0;
            fr_exp     = 1'b1;
         end
      end
      check("fetch_req", bus.fetch_req, fr_exp);
      check("fetch_y", bus.fetch_y, exp_fy);
      check("in_ready", bus.in_ready, src_active);
      check("underrun", underrun, exp_under);

      if (!h1.rst_n || !h2.rst_n) begin
         ehs = 1'b1; evs = 1'b1; ede = 1'b0;
      end else begin
         ehs = h2.hs; evs = h2.vs; ede = h2.de;
      end
      check("hsync", hsync, ehs);
      check("vsync", vsync, evs);
      check("de", de, ede);
      if (!ede) check("rgb_blank", rgb, 12'h000);
      else if (chk_img) check("rgb_pixel", rgb, pix(h2.sx, h2.sy));

      d.rst_n = drv_rst_n;
      d.clr   = drv_clr;
      if (rnd_mode) begin
         d.sx = $urandom_range(0, 1023);
         d.sy = $urandom_range(0, 1023);
         d.hs = 1'($urandom_range(0, 1));
         d.vs = 1'($urandom_range(0, 1));
         d.de = 1'($urandom_range(0, 1));
      end else begin
         d.sx = tx;
         d.sy = ty;
         d.hs = !(tx >= 36 && tx <= 39);
         d.vs = !(ty == 12 || ty == 13);
         d.de = (tx < H) && (ty <= VA);
         if (tx == LN - 1) begin
            tx = 0;
            ty = ny(ty);
         end else begin
            tx++;
         end
      end
      d.active = src_active;
      if (src_active) begin
         if (stall_mode && src_line == 10 && src_idx >= 20) v = 1'b0;
         else if (drop_mode && drops < 12 && $urandom_range(0, 3) == 0) begin
            v = 1'b0;
            drops++;
         end else v = 1'b1;
         data = pix(src_idx, src_line);
      end else begin
         v    = 1'($urandom_range(0, 1));
         data = 12'($urandom);
      end
      d.valid = v;

      sx           = 10'(d.sx);
      sy           = 10'(d.sy);
      hs_in        = d.hs;
      vs_in        = d.vs;
      de_in        = d.de;
      rst_n        = d.rst_n;
      underrun_clr = d.clr;
      bus.in_valid = v;
      bus.in_data  = data;
      h2 = h1;
      h1 = d;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit timed_out;
      rst_n = 1'b0; sx = '0; sy = '0; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
      underrun_clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      h1 = '{0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      h2 = h1;
      rnd_mode = 1'b1; drop_mode = 1'b0; stall_mode = 1'b0; chk_img = 1'b0;
      drv_rst_n = 1'b0; drv_clr = 1'b0;
      src_active = 1'b0; src_idx = 0; src_line = 0; drops = 0;
      exp_under = 1'b0; exp_fy = 0;
      tx = 0; ty = SCR - 1;

      // Reset held with random inputs
      run(3);

      // Two frames with a source that never stalls
      drv_rst_n = 1'b1;
      rnd_mode  = 1'b0;
      chk_img   = 1'b1;
      run(2 * FRAME);

      // Two frames with random valid gaps that still finish within a line
      drop_mode = 1'b1;
      run(2 * FRAME);
      drop_mode = 1'b0;

      // Line 10 stalls after 20 pixels; deadline at the start of line 10
      stall_mode = 1'b1;
      chk_img    = 1'b0;
      run(FRAME);
      check("underrun_sticky", underrun, 1'b1);
      stall_mode = 1'b0;
      drv_clr    = 1'b1;
      step();
      drv_clr    = 1'b0;
      step();
      check("underrun_cleared", underrun, 1'b0);
      chk_img = 1'b1;
      run(FRAME);

      // Reset in the middle of a fill, at 20 accepted pixels
      timed_out = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (src_active && src_idx == 19 && h1.valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      check("midfill_reached", timed_out, 1'b0);
      chk_img   = 1'b0;
      drv_rst_n = 1'b0;
      run(2);
      check("midfill_in_ready", bus.in_ready, 1'b0);
      drv_rst_n = 1'b1;
      timed_out = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (tx == 0 && ty == SCR - 1) begin
            timed_out = 1'b0;
            break;
         end
      end
      check("frame_realign", timed_out, 1'b0);
      chk_img = 1'b1;
      run(FRAME);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
